// File: rtl/spi_link_pkg.sv
// Shared definitions for the panel pixel link transmitter.
package spi_link_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int BIT_CNT_W  = 4;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOW      = 2'd1;
   localparam logic [1:0] ST_HIGH     = 2'd2;
   localparam logic [1:0] ST_LINK_RST = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      LOW      = ST_LOW,
      HIGH     = ST_HIGH,
      LINK_RST = ST_LINK_RST
   } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI clock: counts system clocks while enabled and
// strobes phase_done on the last clock of each CLK_DIV-long half-period.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic phase_done
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] div_cnt;

   // Free-running half-period counter, held at zero whenever disabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= 8'd0;
      end else if (!enable || div_cnt == DIV_LAST) begin
         div_cnt <= 8'd0;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   assign phase_done = enable && (div_cnt == DIV_LAST);

endmodule

// File: rtl/spi_master_tx.sv
// Transmit end of the panel pixel link: serialises 16-bit words MSB first
// onto spi_clk/spi_mosi and drives the receiver realign strobe spi_reset.
//
// Handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both high; tx_data must hold while tx_valid waits. tx_ready
// is decoded from registered state and masked by a present or pending link
// reset request, so a word is never taken in a cycle that realigns.
module spi_master_tx
   import spi_link_pkg::*;
#(
   parameter int CLK_DIV      = 2,
   parameter int RESET_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic                  link_reset_req,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   output logic                  spi_reset,
   output logic                  busy,
   output state_t                fsm_state
);

   localparam logic [7:0]           RST_LAST = 8'(RESET_CYCLES - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_TOP  = BIT_CNT_W'(WORD_WIDTH - 1);

   state_t                state;
   state_t                state_next;
   logic [WORD_WIDTH-2:0] shift_q;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic [7:0]            rst_cnt;
   logic                  pending;
   logic                  phase_done;
   logic                  load;
   logic                  advance;
   logic                  reset_wanted;

   spi_clk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_div (
      .clk       (clk),
      .reset     (reset),
      .enable    ((state == LOW) || (state == HIGH)),
      .phase_done(phase_done)
   );

   assign reset_wanted = pending || link_reset_req;
   assign fsm_state    = state;

   // State register; reset parks the link in LINK_RST so the receiver realigns.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LINK_RST;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode, word load/advance controls and the ready decode.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      tx_ready   = 1'b0;
      case (state)
         IDLE: begin
            tx_ready = !reset_wanted;
            if (reset_wanted) begin
               state_next = LINK_RST;
            end else if (tx_valid) begin
               load       = 1'b1;
               state_next = LOW;
            end
         end
         LOW: begin
            if (phase_done) begin
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (phase_done) begin
               if (bit_cnt != '0) begin
                  advance    = 1'b1;
                  state_next = LOW;
               end else begin
                  tx_ready = !reset_wanted;
                  if (tx_valid && !reset_wanted) begin
                     load       = 1'b1;
                     state_next = LOW;
                  end else if (reset_wanted) begin
                     state_next = LINK_RST;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         LINK_RST: begin
            if (rst_cnt == RST_LAST) begin
               state_next = IDLE;
            end
         end
         default: state_next = LINK_RST;
      endcase
   end

   // Shift register, counters, pending request and registered link outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q   <= '0;
         bit_cnt   <= '0;
         rst_cnt   <= 8'd0;
         pending   <= 1'b0;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         spi_reset <= 1'b1;
         busy      <= 1'b1;
      end else begin
         spi_clk   <= (state_next == HIGH);
         spi_reset <= (state_next == LINK_RST);
         busy      <= (state_next != IDLE);

         if (load) begin
            shift_q  <= tx_data[WORD_WIDTH-2:0];
            spi_mosi <= tx_data[WORD_WIDTH-1];
            bit_cnt  <= BIT_TOP;
         end else if (advance) begin
            shift_q  <= {shift_q[WORD_WIDTH-3:0], 1'b0};
            spi_mosi <= shift_q[WORD_WIDTH-2];
            bit_cnt  <= bit_cnt - 1'b1;
         end else if (state_next == LINK_RST) begin
            spi_mosi <= 1'b0;
         end

         // Counts clocks spent in LINK_RST; zero on every entry.
         if (state == LINK_RST) begin
            rst_cnt <= rst_cnt + 8'd1;
         end else begin
            rst_cnt <= 8'd0;
         end

         // Requests during a word wait for it to finish; several collapse into one.
         if (state_next == LINK_RST) begin
            pending <= 1'b0;
         end else if (link_reset_req && (state == LOW || state == HIGH)) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: instance 0 runs CLK_DIV=2, instance 1 CLK_DIV=1.
// Accepted words go into exp_q; a receiver model watching spi_clk/spi_mosi
// publishes word N on the first bit of word N+1 and compares with exp_q.
module tb_spi_master_tx;
   import spi_link_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset_n[2];
   logic [15:0] tx_data[2];
   logic        tx_valid[2];
   logic        tx_ready[2];
   logic        link_reset_req[2];
   logic        spi_clk[2];
   logic        spi_mosi[2];
   logic        spi_reset[2];
   logic        busy[2];
   state_t      fsm_state[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_master_tx #(
         .CLK_DIV     ((g == 0) ? 2 : 1),
         .RESET_CYCLES(4)
      ) dut (
         .clk           (clk),
         .reset         (reset_n[g]),
         .tx_data       (tx_data[g]),
         .tx_valid      (tx_valid[g]),
         .tx_ready      (tx_ready[g]),
         .link_reset_req(link_reset_req[g]),
         .spi_clk       (spi_clk[g]),
         .spi_mosi      (spi_mosi[g]),
         .spi_reset     (spi_reset[g]),
         .busy          (busy[g]),
         .fsm_state     (fsm_state[g])
      );
   end

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q[$];
   int          edge_cyc[$];
   int          acc_cyc = 0;
   int          dropped_bits = 0;
   int          div_of[2] = '{2, 1};
   logic        prev_clk[2] = '{1'b0, 1'b0};
   logic        prev_mosi[2] = '{1'b0, 1'b0};
   int          stable[2] = '{0, 0};
   int          rx_cnt[2] = '{0, 0};
   logic [15:0] rx_sh[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic rx_compare(input string name, input logic [15:0] word);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got %h, expected no word", name, word);
      end else begin
         check(name, {16'h0, word}, {16'h0, exp_q.pop_front()});
      end
   endtask

   // Receiver model and bit-timing monitor, sampled on the falling clk edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (spi_reset[i]) begin
               if (rx_cnt[i] == 16) begin
                  rx_compare("rx_tail", rx_sh[i]);
               end else if (rx_cnt[i] > 0) begin
                  dropped_bits = rx_cnt[i];
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end
               rx_cnt[i] = 0;
            end
            if (spi_mosi[i] !== prev_mosi[i]) begin
               check("mosi_change_clk_low", {31'h0, spi_clk[i]}, 32'h0);
               stable[i] = 1;
            end else begin
               stable[i]++;
            end
            if (spi_clk[i] && !prev_clk[i]) begin
               edge_cyc.push_back(cyc);
               check("mosi_setup", {31'h0, stable[i] > div_of[i]}, 32'h1);
               if (rx_cnt[i] == 16) begin
                  rx_compare("rx_word", rx_sh[i]);
                  rx_cnt[i] = 0;
               end
               rx_sh[i] = {rx_sh[i][14:0], spi_mosi[i]};
               rx_cnt[i]++;
            end
            prev_clk[i]  = spi_clk[i];
            prev_mosi[i] = spi_mosi[i];
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Offer a word and hold it until accepted; returns the cycles spent waiting.
   task automatic send(input int k, input logic [15:0] d, output int waited);
      waited = 0;
      tx_data[k]  = d;
      tx_valid[k] = 1'b1;
      #1;
      while (!tx_ready[k] && waited < 300) begin
         tick();
         waited++;
         #1;
      end
      if (!tx_ready[k]) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no tx_ready, expected accept of %h", d);
         tx_valid[k] = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back(d);
         #1;
         acc_cyc = cyc;
      end
      tick();
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while (busy[k] && n < 1000) begin
         tick();
         n++;
      end
      if (busy[k]) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=1, expected 0");
      end
   endtask

   task automatic wait_edges(input int want);
      int n;
      n = 0;
      while (edge_cyc.size() < want && n < 500) begin
         tick();
         n++;
      end
      if (edge_cyc.size() < want) begin
         checks++;
         errors++;
         $display("FAIL edge_timeout: got %0d edges, expected %0d", edge_cyc.size(), want);
      end
   endtask

   task automatic pulse_link_reset(input int k);
      link_reset_req[k] = 1'b1;
      tick();
      link_reset_req[k] = 1'b0;
   endtask

   initial begin
      int w;
      int n;
      int ready_seen;
      int rs_cycles;
      int edges_at_rst;
      logic [15:0] d;

      for (int i = 0; i < 2; i++) begin
         reset_n[i]        = 1'b0;
         tx_data[i]        = 16'h0;
         tx_valid[i]       = 1'b0;
         link_reset_req[i] = 1'b0;
      end

      // Reset held 5 clocks, then released.
      repeat (5) @(posedge clk);
      tick();
      check("rst_spi_reset", {31'h0, spi_reset[0]}, 32'h1);
      check("rst_spi_clk", {31'h0, spi_clk[0]}, 32'h0);
      check("rst_spi_mosi", {31'h0, spi_mosi[0]}, 32'h0);
      check("rst_tx_ready", {31'h0, tx_ready[0]}, 32'h0);
      check("rst_busy", {31'h0, busy[0]}, 32'h1);
      check("rst_state", 32'(fsm_state[0]), 32'(LINK_RST));
      check("rst_spi_reset_i1", {31'h0, spi_reset[1]}, 32'h1);
      reset_n[0] = 1'b1;
      reset_n[1] = 1'b1;
      n = 0;
      while (spi_reset[0] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rst_release_cycles", n, 4);
      tick();
      check("idle_tx_ready", {31'h0, tx_ready[0]}, 32'h1);
      check("idle_busy", {31'h0, busy[0]}, 32'h0);
      check("idle_spi_clk", {31'h0, spi_clk[0]}, 32'h0);
      check("idle_state", 32'(fsm_state[0]), 32'(IDLE));

      // Single word, then a dummy word to flush it out of the receiver.
      edge_cyc.delete();
      send(0, 16'hA5C3, w);
      tx_valid[0] = 1'b0;
      wait_idle(0);
      check("word_clocks", cyc - acc_cyc, 64);
      check("word_edges", edge_cyc.size(), 16);
      check("word_bits", {16'h0, rx_sh[0]}, 32'hA5C3);
      send(0, 16'h0000, w);
      tx_valid[0] = 1'b0;
      wait_idle(0);

      // Back-to-back words with tx_valid held high.
      edge_cyc.delete();
      send(0, 16'h0001, w);
      send(0, 16'h8000, w);
      send(0, 16'h0000, w);
      tx_valid[0] = 1'b0;
      wait_idle(0);
      check("b2b_edges", edge_cyc.size(), 48);
      if (edge_cyc.size() >= 33) begin
         check("b2b_period_1", edge_cyc[16] - edge_cyc[0], 64);
         check("b2b_period_2", edge_cyc[32] - edge_cyc[16], 64);
      end

      // Random words with random idle gaps.
      for (int r = 0; r < 6; r++) begin
         d = 16'($urandom);
         send(0, d, w);
         tx_valid[0] = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle(0);

      // Link reset requested mid-word: the word completes, then realign.
      edge_cyc.delete();
      send(0, 16'hFFFF, w);
      tx_valid[0] = 1'b0;
      wait_edges(8);
      pulse_link_reset(0);
      ready_seen   = 0;
      rs_cycles    = 0;
      edges_at_rst = -1;
      n = 0;
      while (busy[0] && n < 500) begin
         ready_seen += int'(tx_ready[0]);
         rs_cycles  += int'(spi_reset[0]);
         if (spi_reset[0] && edges_at_rst < 0) edges_at_rst = edge_cyc.size();
         tick();
         n++;
      end
      check("lr_ready_low", ready_seen, 0);
      check("lr_reset_cycles", rs_cycles, 4);
      check("lr_edges_before_reset", edges_at_rst, 16);

      // Request and word in the same IDLE cycle: request wins.
      tx_data[0]        = 16'h5A5A;
      tx_valid[0]       = 1'b1;
      link_reset_req[0] = 1'b1;
      #1;
      check("req_masks_ready", {31'h0, tx_ready[0]}, 32'h0);
      @(posedge clk);
      #1;
      check("req_spi_reset_next", {31'h0, spi_reset[0]}, 32'h1);
      tick();
      link_reset_req[0] = 1'b0;
      send(0, 16'h5A5A, w);
      check("req_accept_first_idle", w, 4);
      send(0, 16'($urandom), w);
      tx_valid[0] = 1'b0;
      wait_idle(0);
      pulse_link_reset(0);
      wait_idle(0);
      check("inst0_drained", exp_q.size(), 0);

      // CLK_DIV=1: asynchronous reset after 5 bits drops the word.
      edge_cyc.delete();
      send(1, 16'($urandom), w);
      tx_valid[1] = 1'b0;
      wait_edges(5);
      reset_n[1] = 1'b0;
      #1;
      check("async_spi_clk", {31'h0, spi_clk[1]}, 32'h0);
      check("async_spi_mosi", {31'h0, spi_mosi[1]}, 32'h0);
      check("async_spi_reset", {31'h0, spi_reset[1]}, 32'h1);
      repeat (2) tick();
      check("async_dropped_bits", dropped_bits, 5);
      reset_n[1] = 1'b1;
      send(1, 16'h1234, w);
      for (int r = 0; r < 4; r++) begin
         send(1, 16'($urandom), w);
      end
      tx_valid[1] = 1'b0;
      wait_idle(1);
      if (rx_cnt[1] == 16) begin
         rx_compare("rx_tail", rx_sh[1]);
         rx_cnt[1] = 0;
      end
      check("all_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
